matrix_loader: RTL

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_pkg.sv | 17 +
 rtl/matrix_loader_if.sv | 41 ++++
 rtl/mat_word_counter.sv | 30 +++
 rtl/matrix_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared word width, FSM state encoding and sizing helper for the matrix loader.
package matrix_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_LOAD_A  = 2'd1;
    localparam state_t ST_LOAD_B  = 2'd2;
    localparam state_t ST_PRESENT = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Word stream in, two flattened matrices out, with per-matrix strobe/ack.
// in_abort exists only when MATRIX_LOADER_ABORT_EN is defined.
interface matrix_loader_if #(
    parameter int M = 16,
    parameter int P = 16,
    parameter int N = 16
) ();
    import matrix_pkg::*;

    logic [WORD_WIDTH-1:0]         in_data;
    logic                          in_stb;
    logic                          in_ack;
`ifdef MATRIX_LOADER_ABORT_EN
    logic                          in_abort;
`endif
    logic [0:M*P*WORD_WIDTH-1]     matrix_A;
    logic [0:P*N*WORD_WIDTH-1]     matrix_B;
    logic                          a_stb;
    logic                          b_stb;
    logic                          a_ack;
    logic                          b_ack;

    modport master (
        input  in_data, in_stb,
`ifdef MATRIX_LOADER_ABORT_EN
        input  in_abort,
`endif
        output in_ack, matrix_A, matrix_B, a_stb, b_stb,
        input  a_ack, b_ack
    );

    modport slave (
        output in_data, in_stb,
`ifdef MATRIX_LOADER_ABORT_EN
        output in_abort,
`endif
        input  in_ack, matrix_A, matrix_B, a_stb, b_stb,
        output a_ack, b_ack
    );

endinterface

// File: rtl/mat_word_counter.sv
// Word index counter with clear, increment and a terminal-count flag against a
// run-time last index; it saturates at the last index instead of wrapping.
module mat_word_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Loads A then B row-major from a word stream and presents both until each is acked.
// Optional abort input enabled by MATRIX_LOADER_ABORT_EN.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int M = 16,
    parameter int P = 16,
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    matrix_loader_if.master  bus
);

    localparam int A_WORDS = M * P;
    localparam int B_WORDS = P * N;
    localparam int CW      = $clog2(max_int(A_WORDS, B_WORDS) + 1);

    state_t          r_state;
    logic            r_in_ack;
    logic            r_a_stb;
    logic            r_b_stb;

    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   w_last;
    logic            w_tc;
    logic            w_clr;
    logic            w_inc;
    logic            w_loading;
    logic            w_abort;
    logic            w_accept;
    logic            w_wr_a;
    logic            w_wr_b;
    logic            w_a_stb_next;
    logic            w_b_stb_next;

    wire [0:A_WORDS*WORD_WIDTH-1] w_a_flat;
    wire [0:B_WORDS*WORD_WIDTH-1] w_b_flat;

    assign w_loading = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);

`ifdef MATRIX_LOADER_ABORT_EN
    assign w_abort = w_loading && bus.in_abort;
`else
    assign w_abort = 1'b0;
`endif

    // A word offered together with an abort is dropped.
    assign w_accept = bus.in_stb && r_in_ack && !w_abort;
    assign w_wr_a   = w_accept && (r_state == ST_LOAD_A);
    assign w_wr_b   = w_accept && (r_state == ST_LOAD_B);

    assign w_last = (r_state == ST_LOAD_B) ? CW'(B_WORDS - 1) : CW'(A_WORDS - 1);
    assign w_inc  = w_accept && !w_tc;
    assign w_clr  = !w_loading || w_abort || (w_accept && w_tc);

    mat_word_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_last  (w_last),
        .o_count (w_cnt),
        .o_tc    (w_tc)
    );

    assign w_a_stb_next = r_a_stb && !bus.a_ack;
    assign w_b_stb_next = r_b_stb && !bus.b_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_in_ack <= 1'b0;
            r_a_stb  <= 1'b0;
            r_b_stb  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_LOAD_A;
                    r_in_ack <= 1'b1;
                end
                ST_LOAD_A: begin
                    if (!w_abort && w_accept && w_tc) begin
                        r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_abort) begin
                        r_state <= ST_LOAD_A;
                    end else if (w_accept && w_tc) begin
                        r_state  <= ST_PRESENT;
                        r_in_ack <= 1'b0;
                        r_a_stb  <= 1'b1;
                        r_b_stb  <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    r_a_stb <= w_a_stb_next;
                    r_b_stb <= w_b_stb_next;
                    // Reload starts on the very edge the last strobe drops.
                    if (!w_a_stb_next && !w_b_stb_next) begin
                        r_state  <= ST_LOAD_A;
                        r_in_ack <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_in_ack <= 1'b0;
                    r_a_stb  <= 1'b0;
                    r_b_stb  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < A_WORDS; gi++) begin : g_a_word
        logic [WORD_WIDTH-1:0] r_word;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_word <= '0;
            end else if (w_wr_a && (w_cnt == CW'(gi))) begin
                r_word <= bus.in_data;
            end
        end
        assign w_a_flat[gi*WORD_WIDTH +: WORD_WIDTH] = r_word;
    end

    for (genvar gi = 0; gi < B_WORDS; gi++) begin : g_b_word
        logic [WORD_WIDTH-1:0] r_word;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_word <= '0;
            end else if (w_wr_b && (w_cnt == CW'(gi))) begin
                r_word <= bus.in_data;
            end
        end
        assign w_b_flat[gi*WORD_WIDTH +: WORD_WIDTH] = r_word;
    end

    assign bus.in_ack   = r_in_ack;
    assign bus.a_stb    = r_a_stb;
    assign bus.b_stb    = r_b_stb;
    assign bus.matrix_A = w_a_flat;
    assign bus.matrix_B = w_b_flat;

endmodule
